// File: rtl/rca_mp_sequencer.sv
// Multi-precision add sequencer: streams NUM_SLICES slices through one shared
// carry-less adder slice, adding an increment pass whenever a carry enters a slice.
module rca_mp_sequencer #(
    parameter int unsigned SLICE_W    = 14,
    parameter int unsigned NUM_SLICES = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [SLICE_W*NUM_SLICES-1:0] i_op_a,
    input  logic [SLICE_W*NUM_SLICES-1:0] i_op_b,
    input  logic                        i_cin,
    output logic [SLICE_W-1:0]          o_add_term1,
    output logic [SLICE_W-1:0]          o_add_term2,
    input  logic [SLICE_W:0]            i_add_result,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] o_sum,
    output logic                        o_cout,
    output logic                        o_inc_active
);

    localparam int unsigned W   = SLICE_W * NUM_SLICES;
    localparam int unsigned K_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        INC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [K_W-1:0]     k;
    logic               c;
    logic               cp;
    logic [SLICE_W-1:0] t;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       sum_q;
    logic               last_slice;

    assign last_slice = (k == K_W'(NUM_SLICES - 1));

    // All outputs decode from registered state only; no input reaches them.
    always_comb begin
        o_add_term1  = '0;
        o_add_term2  = '0;
        o_inc_active = 1'b0;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        o_sum        = '0;
        o_cout       = 1'b0;
        case (state)
            IDLE: o_ready = 1'b1;
            ADD: begin
                o_add_term1 = a_q[int'(k)*SLICE_W +: SLICE_W];
                o_add_term2 = b_q[int'(k)*SLICE_W +: SLICE_W];
            end
            INC: begin
                o_add_term1  = t;
                o_add_term2  = SLICE_W'(1);
                o_inc_active = 1'b1;
            end
            DONE: begin
                o_valid = 1'b1;
                o_sum   = sum_q;
                o_cout  = c;
            end
            default: ;
        endcase
    end

    // Sequencer: one adder pass per cycle, INC inserted when a carry enters a slice.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            k     <= '0;
            c     <= 1'b0;
            cp    <= 1'b0;
            t     <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_q   <= i_op_a;
                        b_q   <= i_op_b;
                        c     <= i_cin;
                        k     <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    if (!c) begin
                        sum_q[int'(k)*SLICE_W +: SLICE_W] <= i_add_result[SLICE_W-1:0];
                        c <= i_add_result[SLICE_W];
                        if (last_slice) begin
                            state <= DONE;
                        end else begin
                            k <= k + K_W'(1);
                        end
                    end else begin
                        t     <= i_add_result[SLICE_W-1:0];
                        cp    <= i_add_result[SLICE_W];
                        state <= INC;
                    end
                end
                INC: begin
                    sum_q[int'(k)*SLICE_W +: SLICE_W] <= i_add_result[SLICE_W-1:0];
                    c <= cp | i_add_result[SLICE_W];
                    if (last_slice) begin
                        state <= DONE;
                    end else begin
                        k     <= k + K_W'(1);
                        state <= ADD;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_mp_sequencer.sv
// Scoreboard bench for rca_mp_sequencer with a behavioural adder and arithmetic model.
module tb_rca_mp_sequencer;

    localparam int unsigned SW = 14;
    localparam int unsigned NS = 4;
    localparam int unsigned W  = SW * NS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           lat;
        int           ninc;
        int           acc_cyc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          cin;
    logic [SW-1:0] term1;
    logic [SW-1:0] term2;
    logic [SW:0]   add_result;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  o_sum;
    logic          o_cout;
    logic          inc_active;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t sb[$];
    bit   rdy_rand = 0;
    bit   rdy_force_low = 0;

    rca_mp_sequencer #(.SLICE_W(SW), .NUM_SLICES(NS)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_op_a       (op_a),
        .i_op_b       (op_b),
        .i_cin        (cin),
        .o_add_term1  (term1),
        .o_add_term2  (term2),
        .i_add_result (add_result),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_sum        (o_sum),
        .o_cout       (o_cout),
        .o_inc_active (inc_active)
    );

    // Shared carry-less adder slice.
    assign add_result = {1'b0, term1} + {1'b0, term2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: full-width arithmetic; an INC pass happens for every slice whose
    // incoming carry (true carry into bit k*SW of A+B+cin) is 1.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t e;
        logic [W:0]  full;
        logic [63:0] mask;
        logic [63:0] low;
        full   = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ninc = 0;
        for (int s = 0; s < int'(NS); s++) begin
            if (s == 0) begin
                if (ci) e.ninc++;
            end else begin
                mask = (64'd1 << (s * SW)) - 64'd1;
                low  = (64'(a) & mask) + (64'(b) & mask) + 64'(ci);
                if (low[s*SW]) e.ninc++;
            end
        end
        e.lat     = int'(NS) + e.ninc;
        e.acc_cyc = 0;
        return e;
    endfunction

    // Consumer ready, updated shortly after the rising edge.
    always @(posedge clk) begin
        #2;
        if (rdy_force_low) i_ready = 1'b0;
        else if (rdy_rand) i_ready = 1'($urandom_range(0, 1));
        else i_ready = 1'b1;
    end

    // Monitor: pops the scoreboard on each result handshake.
    bit           seen = 0;
    bit           hold = 0;
    int           first_cyc = 0;
    int           inc_cnt = 0;
    logic [W-1:0] held_sum;
    logic         held_cout;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 0; hold = 0; inc_cnt = 0;
        end else begin
            if (inc_active) inc_cnt++;
            if (hold) check("hold_stable", {6'd0, o_valid, o_cout, o_sum}, {6'd0, 1'b1, held_cout, held_sum});
            if (o_valid) begin
                if (!seen) begin
                    seen = 1; first_cyc = cyc;
                end
                if (i_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 64'(o_sum), 64'hDEAD);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("sum", 64'(o_sum), 64'(e.sum));
                        check("cout", 64'(o_cout), 64'(e.cout));
                        check("latency", 64'(first_cyc - e.acc_cyc), 64'(e.lat));
                        check("inc_passes", 64'(inc_cnt), 64'(e.ninc));
                    end
                    seen = 0; hold = 0; inc_cnt = 0;
                end else begin
                    hold = 1; held_sum = o_sum; held_cout = o_cout;
                end
            end else begin
                hold = 0;
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            check("ready_timeout", 64'(o_ready), 64'd1);
            return;
        end
        e = model(a, b, ci);
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        i_valid = 1'b1; op_a = a; op_b = b; cin = ci;
        @(negedge clk);
        i_valid = 1'b0;
        op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom}; cin = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 64'(o_ready), 64'd1);
        check({tag, "_valid"}, 64'(o_valid), 64'd0);
        check({tag, "_terms"}, {36'd0, term1, term2}, 64'd0);
        check({tag, "_inc"}, 64'(inc_active), 64'd0);
    endtask

    localparam logic [W-1:0] ONES = {W{1'b1}};

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           n;
        rst_n = 1'b0; i_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; i_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_sum", 64'(o_sum), 64'd0);
        check("reset_cout", 64'(o_cout), 64'd0);
        rst_n = 1'b1;

        issue(56'd1, 56'd2, 1'b0);
        issue(56'h3FFF, 56'd1, 1'b0);
        issue(ONES, 56'd0, 1'b1);
        issue(ONES, ONES, 1'b1);
        drain();

        // Backpressure with new requests pulsed during DONE.
        rdy_force_low = 1;
        issue(56'h12345678, 56'h0FEDCBA9, 1'b1);
        n = 0;
        while (!o_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 64'(o_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1; op_a = 56'd77; op_b = 56'd88; cin = 1'b1;
            @(negedge clk);
            check("bp_ready_low", 64'(o_ready), 64'd0);
        end
        i_valid = 1'b0;
        rdy_force_low = 0;
        drain();
        repeat (3) begin
            @(negedge clk);
            check("bp_no_extra_valid", 64'(o_valid), 64'd0);
        end

        // Reset in the middle of an INC pass.
        issue(ONES, 56'd0, 1'b1);
        n = 0;
        while (!inc_active && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("inc_seen", 64'(inc_active), 64'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(56'd5, 56'd7, 1'b0);
        drain();

        // Randomized traffic with random consumer stalls.
        rdy_rand = 1;
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) ra = ONES ^ W'($urandom_range(0, 3) << ($urandom_range(0, 3) * SW));
            if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(ra, rb, 1'($urandom));
        end
        drain();
        rdy_rand = 0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rca_mp_sequencer.md
Name: rca_mp_sequencer

Overview:
- Multi-precision add sequencer. Computes one NUM_SLICES×SLICE_W-bit sum by time-multiplexing a single shared SLICE_W-bit ripple-carry adder slice, one slice per pass.
- The adder slice has no carry-in. This block injects carry with a second "increment" pass through the same adder whenever the incoming carry is 1.
- Sits between the operand producer (valid/ready) and the result consumer (valid/ready). It owns the adder's term inputs.

Parameters:
- SLICE_W, 14, width of the shared adder slice (adder result is SLICE_W+1 bits).
- NUM_SLICES, 4, number of slices per operation; operand width W = SLICE_W*NUM_SLICES (56).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  operand request valid.
- o_ready  out  1  block can accept operands.
- i_op_a  in  W  operand A.
- i_op_b  in  W  operand B.
- i_cin  in  1  operation carry-in.
- o_add_term1  out  SLICE_W  to adder term1.
- o_add_term2  out  SLICE_W  to adder term2.
- i_add_result  in  SLICE_W+1  from adder; bit SLICE_W is carry-out; combinational from o_add_term*.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_sum  out  W  result sum.
- o_cout  out  1  result carry-out.
- o_inc_active  out  1  current cycle is an INC pass.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE. o_ready=1. o_valid=0, o_sum=0, o_cout=0, o_inc_active=0, o_add_term1=0, o_add_term2=0. All internal registers cleared. Reset mid-operation abandons the operation; no partial result is ever presented.
- o_add_term1/o_add_term2/o_inc_active/o_ready/o_valid decode from registers only; there is no combinational path from any input.
- States: IDLE, ADD, INC, DONE. Internal registers: slice index k, carry c, pending carry cp, temp sum t, operand copies, sum register.
- IDLE:
  - o_ready=1; terms driven 0.
  - On i_valid: capture i_op_a, i_op_b, c<=i_cin, k<=0, go ADD.
- ADD:
  - Drive term1=A slice k, term2=B slice k. Sample i_add_result (r) at the cycle end.
  - If c=0: sum slice k<=r[SLICE_W-1:0], c<=r[SLICE_W]. Then go to DONE if k=NUM_SLICES-1, else k<=k+1 and stay in ADD.
  - If c=1: t<=r[SLICE_W-1:0], cp<=r[SLICE_W], go INC.
- INC:
  - o_inc_active=1. Drive term1=t, term2=1 (zero-extended). Sample r.
  - sum slice k<=r[SLICE_W-1:0], c<=cp|r[SLICE_W] (cp and r[SLICE_W] are never both 1).
  - Advance as in ADD (DONE after last slice).
- DONE:
  - o_valid=1, o_sum=sum register, o_cout=c. o_sum/o_cout are held stable while i_ready=0.
  - On i_ready: go IDLE and o_valid drops next cycle. A new accept is possible one cycle later (no same-cycle turnaround).
- Latency: o_valid rises NUM_SLICES+n_inc cycles after the accepting edge, where n_inc is the number of slices entered with c=1. Minimum 4, maximum 8 at defaults.
- i_valid outside IDLE is ignored; i_op_a/i_op_b/i_cin changes after accept do not affect the result.
- k wraps nowhere. The final carry goes to o_cout only and is never fed into another operation.
- Result must equal (A+B+cin) mod 2^W, with o_cout = bit W of that sum.

Test Plan:
- A=1, B=2, cin=0 -> o_sum=3, o_cout=0; o_valid 4 cycles after accept; o_inc_active never 1.
- A=0x3FFF, B=1, cin=0 -> o_sum=0x4000, o_cout=0; exactly one INC pass (slice 1); latency 5.
- A=0xFFFFFFFFFFFFFF, B=0, cin=1 -> o_sum=0, o_cout=1; INC on every slice; latency 8.
- A=B=0xFFFFFFFFFFFFFF, cin=1 -> o_sum=0xFFFFFFFFFFFFFF, o_cout=1; latency 8.
- Backpressure: hold i_ready=0 for 3 cycles in DONE while pulsing i_valid with new operands -> o_valid, o_sum, o_cout stable; o_ready=0; the new operands are not accepted.
- Assert i_rst_n=0 during an INC pass -> immediately o_valid=0, o_ready=1, terms=0. The next operation (5+7, cin=0) returns 12 with latency 4.
